// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate-generation pipeline.
package imm_pkg;

    localparam int XLEN_32 = 32;
    localparam int XLEN_64 = 64;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    function automatic logic xlen_ok(int x);
        return (x == XLEN_32) || (x == XLEN_64);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RV immediate extraction and sign extension to XLEN.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm_ext,
    output logic            imm_err
);

    if (!xlen_ok(XLEN)) begin : g_xlen_bad
        $error("imm_decode: XLEN must be 32 or 64");
    end

    logic [31:0] imm32;
    logic        unused_opcode;

    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm32   = '0;
        imm_err = 1'b0;
        case (imm_src_t'(imm_src))
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'h000};
            default: imm_err = 1'b1;
        endcase
        // 32-bit value is already sign-correct; widen by sign extension
        imm_ext = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-entry (main + skid) buffered immediate generator with valid/ready.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_ext,
    output logic [TAG_W-1:0] out_tag,
    output logic             imm_err
);

    buf_state_t       state_q, state_d;
    logic [XLEN-1:0]  main_imm_q, main_imm_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic             main_err_q, main_err_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             skid_err_q, skid_err_d;

    logic [XLEN-1:0]  new_imm;
    logic             new_err;
    logic             in_fire;
    logic             out_fire;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (instr),
        .imm_src (imm_src),
        .imm_ext (new_imm),
        .imm_err (new_err)
    );

    // Ready depends only on registered state, never on out_ready
    assign in_ready  = (state_q != BUF_TWO);
    assign out_valid = (state_q != BUF_EMPTY);
    assign imm_ext   = main_imm_q;
    assign out_tag   = main_tag_q;
    assign imm_err   = main_err_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_tag_d = main_tag_q;
        main_err_d = main_err_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;
        skid_err_d = skid_err_q;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            unique case (state_q)
                BUF_EMPTY: begin
                    if (in_fire) begin
                        main_imm_d = new_imm;
                        main_tag_d = in_tag;
                        main_err_d = new_err;
                        state_d    = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (in_fire && out_fire) begin
                        main_imm_d = new_imm;
                        main_tag_d = in_tag;
                        main_err_d = new_err;
                    end else if (in_fire) begin
                        skid_imm_d = new_imm;
                        skid_tag_d = in_tag;
                        skid_err_d = new_err;
                        state_d    = BUF_TWO;
                    end else if (out_fire) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (out_fire) begin
                        main_imm_d = skid_imm_q;
                        main_tag_d = skid_tag_q;
                        main_err_d = skid_err_q;
                        state_d    = BUF_ONE;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BUF_EMPTY;
            main_imm_q <= '0;
            main_tag_q <= '0;
            main_err_q <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_imm_q <= main_imm_d;
            main_tag_q <= main_tag_d;
            main_err_q <= main_err_d;
            skid_imm_q <= skid_imm_d;
            skid_tag_q <= skid_tag_d;
            skid_err_q <= skid_err_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_gen_pipe;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  imm_src;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, err32;
    logic [31:0] imm32;
    logic [4:0]  tag32;
    logic        in_ready64, out_valid64, err64;
    logic [63:0] imm64;
    logic [4:0]  tag64;

    int n_chk = 0;
    int n_bad = 0;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready32),
        .instr     (instr),
        .imm_src   (imm_src),
        .in_tag    (in_tag),
        .out_valid (out_valid32),
        .out_ready (out_ready),
        .imm_ext   (imm32),
        .out_tag   (tag32),
        .imm_err   (err32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready64),
        .instr     (instr),
        .imm_src   (imm_src),
        .in_tag    (in_tag),
        .out_valid (out_valid64),
        .out_ready (out_ready),
        .imm_ext   (imm64),
        .out_tag   (tag64),
        .imm_err   (err64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    logic [31:0] v_instr [8] = '{32'hFFF00093, 32'h00112623, 32'hFE000EE3,
                                 32'h001000EF, 32'h12345037, 32'h80000037,
                                 32'hFFFFFFFF, 32'hFFF00093};
    logic [2:0]  v_src   [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd7, 3'd0};
    logic [4:0]  v_tag   [8] = '{5'd1, 5'd2, 5'd3, 5'd7, 5'd4, 5'd5, 5'd6, 5'd8};
    logic [31:0] v_e32   [8] = '{32'hFFFFFFFF, 32'h0000000C, 32'hFFFFFFFC,
                                 32'h00000800, 32'h12345000, 32'h80000000,
                                 32'h00000000, 32'hFFFFFFFF};
    logic [63:0] v_e64   [8] = '{64'hFFFFFFFF_FFFFFFFF, 64'h0000000C,
                                 64'hFFFFFFFF_FFFFFFFC, 64'h00000800,
                                 64'h00000000_12345000, 64'hFFFFFFFF_80000000,
                                 64'h0, 64'hFFFFFFFF_FFFFFFFF};
    logic        v_err   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] w,
                         input logic [2:0] s, input logic [4:0] t);
        in_valid = v;
        instr    = w;
        imm_src  = s;
        in_tag   = t;
    endtask

    // I-type word whose immediate equals the tag
    function automatic logic [31:0] iw(input logic [4:0] t);
        return {7'd0, t, 20'h00093};
    endfunction

    task automatic chk_vec(input int k);
        chk($sformatf("v%0d_valid", k), 64'(out_valid32), 64'd1);
        chk($sformatf("v%0d_imm32", k), 64'(imm32), 64'(v_e32[k]));
        chk($sformatf("v%0d_imm64", k), imm64, v_e64[k]);
        chk($sformatf("v%0d_tag", k), 64'(tag32), 64'(v_tag[k]));
        chk($sformatf("v%0d_err", k), 64'(err32), 64'(v_err[k]));
        chk($sformatf("v%0d_err64", k), 64'(err64), 64'(v_err[k]));
    endtask

    task automatic chk_tag(input string nm, input logic [4:0] t);
        chk({nm, "_valid"}, 64'(out_valid32), 64'd1);
        chk({nm, "_tag"}, 64'(tag32), 64'(t));
        chk({nm, "_imm"}, 64'(imm32), 64'(t));
        chk({nm, "_tag64"}, 64'(tag64), 64'(t));
    endtask

    task automatic chk_empty(input string nm);
        chk({nm, "_ovalid"}, 64'(out_valid32), 64'd0);
        chk({nm, "_iready"}, 64'(in_ready32), 64'd1);
        chk({nm, "_ovalid64"}, 64'(out_valid64), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 3'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_empty("rst");
        chk("rst_imm32", 64'(imm32), 64'd0);
        chk("rst_imm64", imm64, 64'd0);
        chk("rst_tag", 64'(tag32), 64'd0);
        chk("rst_err", 64'(err32), 64'd0);

        // streaming: one result per cycle, one cycle latency
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 drive(1'b1, v_instr[i], v_src[i], v_tag[i]);
            @(negedge clk);
            chk($sformatf("s%0d_iready", i), 64'(in_ready32), 64'd1);
            if (i > 0) chk_vec(i - 1);
        end
        @(posedge clk);
        #1 drive(1'b0, 32'd0, 3'd0, 5'd0);
        @(negedge clk);
        chk_vec(7);
        @(posedge clk);
        @(negedge clk);
        chk_empty("drain");

        // backpressure: tags 1,2,3 with out_ready low
        @(posedge clk);
        #1 out_ready = 1'b0;
        drive(1'b1, iw(5'd1), 3'd0, 5'd1);
        @(posedge clk);
        #1 drive(1'b1, iw(5'd2), 3'd0, 5'd2);
        @(negedge clk);
        chk("bp1_iready", 64'(in_ready32), 64'd1);
        chk_tag("bp1", 5'd1);
        @(posedge clk);
        #1 drive(1'b1, iw(5'd3), 3'd0, 5'd3);
        @(negedge clk);
        chk("bp2_iready", 64'(in_ready32), 64'd0);
        chk("bp2_iready64", 64'(in_ready64), 64'd0);
        chk_tag("bp2", 5'd1);
        @(posedge clk);
        @(negedge clk);
        chk("bp3_iready", 64'(in_ready32), 64'd0);
        chk_tag("bp3_hold", 5'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp4_iready", 64'(in_ready32), 64'd1);
        chk_tag("bp4", 5'd2);
        @(posedge clk);
        #1 drive(1'b0, 32'd0, 3'd0, 5'd0);
        @(negedge clk);
        chk_tag("bp5", 5'd3);
        @(posedge clk);
        @(negedge clk);
        chk_empty("bp6");

        // flush in TWO with simultaneous in_valid
        @(posedge clk);
        #1 out_ready = 1'b0;
        drive(1'b1, iw(5'd9), 3'd0, 5'd9);
        @(posedge clk);
        #1 drive(1'b1, iw(5'd10), 3'd0, 5'd10);
        @(posedge clk);
        #1 flush = 1'b1;
        drive(1'b1, iw(5'd11), 3'd0, 5'd11);
        @(negedge clk);
        chk("fl_two_iready", 64'(in_ready32), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 3'd0, 5'd0);
        @(negedge clk);
        chk_empty("fl_two");
        @(posedge clk);
        @(negedge clk);
        chk_empty("fl_two_b");
        @(posedge clk);
        #1 drive(1'b1, iw(5'd12), 3'd0, 5'd12);
        @(posedge clk);
        #1 drive(1'b0, 32'd0, 3'd0, 5'd0);
        @(negedge clk);
        chk_tag("fl_after", 5'd12);
        @(posedge clk);
        @(negedge clk);
        chk_empty("fl_after_e");

        // flush in ONE while an input would be accepted
        @(posedge clk);
        #1 out_ready = 1'b0;
        drive(1'b1, iw(5'd13), 3'd0, 5'd13);
        @(posedge clk);
        #1 flush = 1'b1;
        drive(1'b1, iw(5'd14), 3'd0, 5'd14);
        @(posedge clk);
        #1 flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 3'd0, 5'd0);
        @(negedge clk);
        chk_empty("fl_one");

        // reset (with flush) in TWO with simultaneous in_valid
        @(posedge clk);
        #1 out_ready = 1'b0;
        drive(1'b1, iw(5'd15), 3'd7, 5'd15);
        @(posedge clk);
        #1 drive(1'b1, iw(5'd16), 3'd0, 5'd16);
        @(posedge clk);
        #1 reset = 1'b1;
        flush = 1'b1;
        drive(1'b1, iw(5'd17), 3'd0, 5'd17);
        @(posedge clk);
        #1 reset = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 3'd0, 5'd0);
        @(negedge clk);
        chk_empty("rs_two");
        chk("rs_two_imm", 64'(imm32), 64'd0);
        chk("rs_two_tag", 64'(tag32), 64'd0);
        chk("rs_two_err", 64'(err32), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk_empty("rs_two_b");
        @(posedge clk);
        #1 drive(1'b1, iw(5'd18), 3'd0, 5'd18);
        @(posedge clk);
        #1 drive(1'b0, 32'd0, 3'd0, 5'd0);
        @(negedge clk);
        chk_tag("rs_after", 5'd18);
        chk("rs_after_err", 64'(err32), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
